// File: rtl/ram_block_copier.sv
// DMA engine for the dual-port RAM: block copy (port-0 reads, port-1 writes,
// two-stage pipeline over the registered read) or constant fill, with done pulse.
//
// state  | meaning
// S_IDLE | waiting for start; inputs latched on accept
// S_COPY | issuing reads on port 0 and draining writes on port 1
// S_FILL | writing the latched fill pattern, one word per cycle
// S_DONE | one-cycle completion, done high
module ram_block_copier #(
    parameter  int DATA_N = 32,
    parameter  int SIZE   = 128,
    localparam int AW     = $clog2(SIZE),
    localparam int LW     = $clog2(SIZE) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [AW-1:0]     src_addr_i,
    input  logic [AW-1:0]     dst_addr_i,
    input  logic [LW-1:0]     len_i,
    input  logic [DATA_N-1:0] fill_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              we0_o,
    output logic [AW-1:0]     addr0_o,
    output logic [DATA_N-1:0] w0_data_o,
    input  logic [DATA_N-1:0] r0_data_i,
    output logic              we1_o,
    output logic [AW-1:0]     addr1_o,
    output logic [DATA_N-1:0] w1_data_o,
    input  logic [DATA_N-1:0] r1_data_i
);

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_FILL, S_DONE} state_t;

    state_t            state_q;
    logic [AW-1:0]     src_q, dst_q;
    logic [LW-1:0]     len_q, idx_q, tmr_q;
    logic              desc_q;
    logic              v0_q, v1_q;
    logic [AW-1:0]     off0_q, off1_q;
    logic              busy_q, done_q, we1_q;
    logic [AW-1:0]     addr0_q, addr1_q;
    logic [DATA_N-1:0] w1_data_q;

    logic              desc_d;
    logic [AW-1:0]     st_off_d, rd_off_d;
    logic              unused_r1;

    // Descending order keeps an overlapping copy from reading already-written words.
    assign desc_d   = dst_addr_i > src_addr_i;
    assign st_off_d = desc_d ? len_i[AW-1:0] - AW'(1) : '0;
    assign rd_off_d = desc_q ? len_q[AW-1:0] - idx_q[AW-1:0] - AW'(1) : idx_q[AW-1:0];
    assign unused_r1 = ^r1_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            tmr_q     <= '0;
            desc_q    <= 1'b0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            off0_q    <= '0;
            off1_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we1_q     <= 1'b0;
            addr0_q   <= '0;
            addr1_q   <= '0;
            w1_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    we1_q <= 1'b0;
                    if (start_i) begin
                        src_q  <= src_addr_i;
                        dst_q  <= dst_addr_i;
                        len_q  <= len_i;
                        desc_q <= desc_d;
                        idx_q  <= LW'(1);
                        v1_q   <= 1'b0;
                        if (len_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (!mode_i) begin
                            state_q <= S_COPY;
                            busy_q  <= 1'b1;
                            addr0_q <= src_addr_i + st_off_d;
                            off0_q  <= st_off_d;
                            v0_q    <= 1'b1;
                            tmr_q   <= len_i + LW'(1);
                        end else begin
                            state_q   <= S_FILL;
                            busy_q    <= 1'b1;
                            we1_q     <= 1'b1;
                            addr1_q   <= dst_addr_i;
                            w1_data_q <= fill_data_i;
                        end
                    end
                end
                S_COPY: begin
                    // Stage 1 waits out the RAM read latency, stage 2 presents the write.
                    v1_q   <= v0_q;
                    off1_q <= off0_q;
                    we1_q  <= v1_q;
                    if (v1_q) begin
                        addr1_q   <= dst_q + off1_q;
                        w1_data_q <= r0_data_i;
                    end
                    if (idx_q < len_q) begin
                        addr0_q <= src_q + rd_off_d;
                        off0_q  <= rd_off_d;
                        v0_q    <= 1'b1;
                        idx_q   <= idx_q + LW'(1);
                    end else begin
                        v0_q <= 1'b0;
                    end
                    if (tmr_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - LW'(1);
                    end
                end
                S_FILL: begin
                    if (idx_q == len_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        we1_q   <= 1'b0;
                    end else begin
                        we1_q   <= 1'b1;
                        addr1_q <= dst_q + idx_q[AW-1:0];
                        idx_q   <= idx_q + LW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    we1_q   <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign we0_o     = 1'b0;
    assign addr0_o   = addr0_q;
    assign w0_data_o = '0;
    assign we1_o     = we1_q;
    assign addr1_o   = addr1_q;
    assign w1_data_o = w1_data_q;

endmodule

// File: tb/tb_ram_block_copier.sv
// Bench for ram_block_copier: behavioural dual-port RAM plus a memmove/fill
// reference model with cycle-level busy/done expectations.
module tb_ram_block_copier;

    logic        clk = 1'b0;
    logic        rst, start, mode;
    logic [6:0]  src, dst;
    logic [7:0]  len;
    logic [31:0] fill;
    logic        busy, done, we0, we1;
    logic [6:0]  addr0, addr1;
    logic [31:0] w0_data, w1_data, r0_data, r1_data;

    logic [31:0] mem  [128];
    logic [31:0] seed [128];
    logic [31:0] exp_m[128];
    logic        init_req = 1'b0;
    int          wr_cnt = 0, bad_wr = 0;
    int          win_base = 0, win_len = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    ram_block_copier #(.DATA_N(32), .SIZE(128)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .src_addr_i(src), .dst_addr_i(dst), .len_i(len), .fill_data_i(fill),
        .busy_o(busy), .done_o(done), .we0_o(we0), .addr0_o(addr0),
        .w0_data_o(w0_data), .r0_data_i(r0_data), .we1_o(we1), .addr1_o(addr1),
        .w1_data_o(w1_data), .r1_data_i(r1_data)
    );

    // RAM fixture: registered reads on both ports, write on port 1
    always @(posedge clk) begin
        r0_data <= mem[addr0];
        r1_data <= mem[addr1];
        if (init_req) begin
            for (int i = 0; i < 128; i++) mem[i] <= seed[i];
        end else if (we1) begin
            mem[addr1] <= w1_data;
            wr_cnt <= wr_cnt + 1;
            if (((int'(addr1) - win_base + 128) % 128) >= win_len) bad_wr <= bad_wr + 1;
        end
    end

    task automatic preload();
        for (int i = 0; i < 128; i++) seed[i] = exp_m[i];
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
    endtask

    task automatic check_mem(input string name);
        int diff, first;
        diff = 0; first = -1;
        for (int i = 0; i < 128; i++)
            if (mem[i] !== exp_m[i]) begin diff++; if (first < 0) first = i; end
        checks++;
        if (diff != 0) begin
            errors++;
            $display("FAIL %s mem: %0d words differ, first M[%0d]=%h required %h",
                     name, diff, first, mem[first], exp_m[first]);
        end
    endtask

    task automatic scramble();
        mode = 1'($urandom); src = 7'($urandom); dst = 7'($urandom);
        len = 8'($urandom_range(0, 128)); fill = $urandom;
    endtask

    // hold: 0 = single pulse, 1 = start held until done, 2 = extra pulse mid-transfer
    task automatic run_op(input string name, input logic m, input int s, input int d,
                          input int n, input logic [31:0] f, input int hold);
        logic [31:0] tmp [128];
        int busy_n, done_n, done_at, wr0, bad0, exp_busy, exp_done;
        busy_n = 0; done_n = 0; done_at = -1;
        if (m) begin
            for (int k = 0; k < n; k++) exp_m[(d + k) % 128] = f;
        end else begin
            for (int k = 0; k < n; k++) tmp[k] = exp_m[(s + k) % 128];
            for (int k = 0; k < n; k++) exp_m[(d + k) % 128] = tmp[k];
        end
        exp_busy = (n == 0) ? 0 : (m ? n : n + 2);
        exp_done = (n == 0) ? 0 : (m ? n : n + 2);
        win_base = d; win_len = n; wr0 = wr_cnt; bad0 = bad_wr;
        @(negedge clk);
        start = 1'b1; mode = m; src = s[6:0]; dst = d[6:0]; len = n[7:0]; fill = f;
        @(posedge clk);
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin done_n++; if (done_at < 0) done_at = j; end
            if (hold == 1 && done_at < 0) begin start = 1'b1; scramble(); end
            else if (hold == 2 && j == 2) begin start = 1'b1; scramble(); end
            else start = 1'b0;
            if (done_at >= 0 && j >= done_at + 3) break;
        end
        start = 1'b0;
        checks++;
        if (done_at < 0) begin
            errors++; $display("FAIL %s timeout: no done within 400 cycles", name);
        end
        checks++;
        if (busy_n !== exp_busy) begin
            errors++; $display("FAIL %s busy_cycles got %0d required %0d", name, busy_n, exp_busy);
        end
        checks++;
        if (done_n !== 1) begin
            errors++; $display("FAIL %s done_pulses got %0d required 1", name, done_n);
        end
        checks++;
        if (done_at !== exp_done) begin
            errors++; $display("FAIL %s done_edge got %0d required %0d", name, done_at, exp_done);
        end
        checks++;
        if (wr_cnt - wr0 !== n) begin
            errors++; $display("FAIL %s write_count got %0d required %0d", name, wr_cnt - wr0, n);
        end
        checks++;
        if (bad_wr !== bad0) begin
            errors++; $display("FAIL %s out_of_window_writes got %0d required 0", name, bad_wr - bad0);
        end
        check_mem(name);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill = '0;
        for (int i = 0; i < 128; i++) exp_m[i] = $urandom;
        preload();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, we1, we0} !== 4'b0000) begin
            errors++; $display("FAIL reset flags busy/done/we1/we0 got %b required 0000", {busy, done, we1, we0});
        end
        checks++;
        if ({addr0, addr1} !== 14'd0) begin
            errors++; $display("FAIL reset addr got %h/%h required 0/0", addr0, addr1);
        end
        checks++;
        if ({w1_data, w0_data} !== 64'd0) begin
            errors++; $display("FAIL reset wdata got %h/%h required 0/0", w1_data, w0_data);
        end
        rst = 1'b0;
        @(negedge clk);
        check_mem("reset_no_write");
    endtask

    task automatic test_copy_asc();
        for (int i = 10; i < 14; i++) exp_m[i] = $urandom;
        preload();
        run_op("copy_asc", 1'b0, 10, 50, 4, 32'h0, 0);
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 8; i++) exp_m[20 + i] = 32'(i);
        preload();
        run_op("overlap_desc", 1'b0, 20, 22, 6, 32'h0, 0);
        for (int i = 0; i < 8; i++) exp_m[20 + i] = 32'(i);
        preload();
        run_op("overlap_asc", 1'b0, 22, 20, 6, 32'h0, 0);
    endtask

    task automatic test_fill_wrap();
        run_op("fill_wrap", 1'b1, 0, 126, 4, 32'hDEADBEEF, 0);
    endtask

    task automatic test_len_edges();
        run_op("len0_copy", 1'b0, 5, 70, 0, 32'h0, 0);
        run_op("len0_fill", 1'b1, 5, 70, 0, 32'h12345678, 0);
        run_op("len_full", 1'b0, 0, 0, 128, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        run_op("start_held", 1'b0, 30, 40, 7, 32'h0, 1);
        run_op("start_repulse", 1'b1, 0, 100, 9, 32'hA5A5_0F0F, 2);
        run_op("next_after_idle", 1'b0, 100, 3, 5, 32'h0, 0);
    endtask

    task automatic test_reset_mid();
        int wr0, bad0, done_n;
        exp_m[97] = exp_m[67];
        win_base = 90; win_len = 8; wr0 = wr_cnt; bad0 = bad_wr; done_n = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src = 7'd60; dst = 7'd90; len = 8'd8;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, we1} !== 3'b000) begin
            errors++; $display("FAIL reset_mid busy/done/we1 got %b required 000", {busy, done, we1});
        end
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (done || busy || we1) done_n++;
        end
        checks++;
        if (done_n !== 0) begin
            errors++; $display("FAIL reset_mid activity_after_abort got %0d required 0", done_n);
        end
        checks++;
        if (wr_cnt - wr0 !== 1 || bad_wr !== bad0) begin
            errors++; $display("FAIL reset_mid writes got %0d required 1", wr_cnt - wr0);
        end
        check_mem("reset_mid");
        run_op("after_abort", 1'b0, 60, 90, 8, 32'h0, 0);
    endtask

    task automatic test_random();
        int n, s, d;
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 64);
            s = $urandom_range(0, 128 - n);
            d = $urandom_range(0, 128 - n);
            run_op("random", 1'($urandom), s, d, n, $urandom, 0);
        end
    endtask

    initial begin
        test_reset();
        test_copy_asc();
        test_overlap();
        test_fill_wrap();
        test_len_edges();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
